// File: rtl/pe_operand_feeder.sv
// Operand feeder for one FP16 MAC processing element: FIFO-buffered (a,b) pairs, K-term dot-product sequencing.
// Optional build macro FEEDER_ZERO_SKIP_EN suppresses pe_en for pairs holding a +/-0 operand.
module pe_operand_feeder #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 4,
  parameter int LEN_W        = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              pe_clr,
  output logic              pe_en,
  output logic [DATA_W-1:0] pe_a,
  output logic [DATA_W-1:0] pe_b,
  input  logic [DATA_W-1:0] pe_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW:0]    LP_FULL  = (AW + 1)'(DEPTH);
  localparam logic [DCW-1:0] LP_DRAIN = DCW'(DRAIN_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_HOLD} state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_mem_a [DEPTH];
  logic [DATA_W-1:0] r_mem_b [DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic              r_in_ready;
  logic [LEN_W-1:0]  r_rem;
  logic [DCW-1:0]    r_drain;
  logic              r_pe_clr_p1, r_pe_en_p1;
  logic [DATA_W-1:0] r_pe_a_p1, r_pe_b_p1;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;

  logic [AW:0]       w_count, w_count_nxt;
  logic              w_empty, w_push, w_pop, w_issue, w_head_zero;
  logic [DATA_W-1:0] w_head_a, w_head_b;

`ifdef FEEDER_ZERO_SKIP_EN
  function automatic logic is_signed_zero(input logic [DATA_W-1:0] v);
    return v[DATA_W-2:0] == '0;
  endfunction
  assign w_head_zero = is_signed_zero(w_head_a) || is_signed_zero(w_head_b);
`else
  assign w_head_zero = 1'b0;
`endif

  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (w_count == '0);
  assign w_push      = in_valid && r_in_ready;
  // STREAM is left on the last pop, so rem is never 0 while popping here.
  assign w_pop       = (r_state == S_STREAM) && !w_empty;
  assign w_issue     = w_pop && !w_head_zero;
  assign w_count_nxt = w_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
  assign w_head_a    = r_mem_a[r_rd_ptr[AW-1:0]];
  assign w_head_b    = r_mem_b[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_CLEAR;
      S_CLEAR:  w_state_nxt = (r_rem != '0) ? S_STREAM : S_HOLD;
      S_STREAM: if (w_pop && r_rem == LEN_W'(1)) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_drain == DCW'(1)) w_state_nxt = S_HOLD;
      S_HOLD:   if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr[AW-1:0]] <= in_a;
      r_mem_b[r_wr_ptr[AW-1:0]] <= in_b;
    end
  end

  // p0 -> p1: FIFO head registered onto the PE operand ports
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_in_ready  <= 1'b0;
      r_rem       <= '0;
      r_drain     <= '0;
      r_pe_clr_p1 <= 1'b0;
      r_pe_en_p1  <= 1'b0;
      r_pe_a_p1   <= '0;
      r_pe_b_p1   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_in_ready  <= (w_count_nxt != LP_FULL);
      r_pe_clr_p1 <= (r_state == S_IDLE) && start;
      r_pe_en_p1  <= w_issue;
      if (w_issue) begin
        r_pe_a_p1 <= w_head_a;
        r_pe_b_p1 <= w_head_b;
      end
      if (r_state == S_IDLE && start) r_rem <= len;
      if (w_pop) begin
        r_rem <= r_rem - LEN_W'(1);
        if (r_rem == LEN_W'(1)) r_drain <= LP_DRAIN;
      end
      if (r_state == S_DRAIN) r_drain <= r_drain - DCW'(1);
      // p1 -> result: capture P once the PE pipeline has flushed
      if (r_state == S_CLEAR && r_rem == '0) begin
        r_out_data  <= '0;
        r_out_valid <= 1'b1;
      end else if (r_state == S_DRAIN && r_drain == DCW'(1)) begin
        r_out_data  <= pe_p;
        r_out_valid <= 1'b1;
      end else if (r_state == S_HOLD && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign pe_clr    = r_pe_clr_p1;
  assign pe_en     = r_pe_en_p1;
  assign pe_a      = r_pe_a_p1;
  assign pe_b      = r_pe_b_p1;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_out_valid && out_ready;

endmodule
